// File: rtl/wb_core_arbiter_pkg.sv
// Shared definitions for the Wishbone core arbiter.
// Holds the FSM state encoding, Wishbone CTI/BTE codes, the watchdog
// counter width and an index-width helper.
package wb_arb_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Wishbone cycle type / burst type field widths and codes
  localparam int unsigned CTI_W = 3;
  localparam int unsigned BTE_W = 2;

  localparam logic [CTI_W-1:0] CTI_CLASSIC   = 3'b000;
  localparam logic [CTI_W-1:0] CTI_INC_BURST = 3'b010;
  localparam logic [CTI_W-1:0] CTI_END_BURST = 3'b111;
  localparam logic [BTE_W-1:0] BTE_LINEAR    = 2'b00;

  // Watchdog stall counter width
  localparam int unsigned WDOG_W = 16;

  // Index width that stays at least one bit for a single core
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_core_arbiter_if.sv
// Flattened Wishbone bus bundle carrying LANES parallel masters.
// Lane i of every field occupies slice [w*(i+1)-1 : w*i].
// Ports (per lane): adr, dat_w, sel, we, cyc, stb, cti, bte  (request)
//                   dat_r, ack, err, rty                     (response)
// modport master: drives requests, receives responses.
// modport slave : receives requests, drives responses.
interface wb_core_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int unsigned LANES = 1,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  localparam int unsigned SW = DW / 8;

  logic [AW*LANES-1:0]    adr;
  logic [DW*LANES-1:0]    dat_w;
  logic [SW*LANES-1:0]    sel;
  logic [LANES-1:0]       we;
  logic [LANES-1:0]       cyc;
  logic [LANES-1:0]       stb;
  logic [CTI_W*LANES-1:0] cti;
  logic [BTE_W*LANES-1:0] bte;
  logic [DW*LANES-1:0]    dat_r;
  logic [LANES-1:0]       ack;
  logic [LANES-1:0]       err;
  logic [LANES-1:0]       rty;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err, rty
  );

endinterface

// File: rtl/wb_core_arbiter_rr_priority_picker.sv
// Round-robin priority picker: returns a one-hot grant for the first
// requester found searching upward from last_grant+1, wrapping at N-1.
// Ports: req (N) request vector, last_grant (IDXW) previous winner,
//        grant (N) one-hot pick, all zero when nothing requests.
module rr_priority_picker #(
  parameter int unsigned N    = 1,
  parameter int unsigned IDXW = 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last_grant,
  output logic [N-1:0]    grant
);

  // Scan N candidates starting just past the previous winner
  always_comb begin
    logic            found;
    logic [IDXW-1:0] cand;
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDXW'((32'(last_grant) + k) % N);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_core_arbiter.sv
// Round-robin arbiter folding NUM_CORES Wishbone masters onto one
// downstream master port. One-cycle grant latency, grant held for the
// whole cyc, at least one idle cycle between grants.
// Optional macro WB_ARB_WATCHDOG_EN: stalled-transfer watchdog that
// errors the granted master after TIMEOUT unanswered strobe cycles.
// Ports:
//   wb_clk_i   clock
//   wb_rst_ni  async active-low reset
//   wbm        upstream masters (NUM_CORES lanes), slave modport
//   wbs        downstream port (1 lane), master modport
//   grant_o    one-hot current grant, zero when idle
module wb_core_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES = 1,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  wb_core_arbiter_if.slave     wbm,
  wb_core_arbiter_if.master    wbs,
  output logic [NUM_CORES-1:0] grant_o
);

  localparam int unsigned SW   = DW / 8;
  localparam int unsigned IDXW = idx_width(NUM_CORES);

  logic [0:0]           state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [NUM_CORES-1:0] pick;
  logic [IDXW-1:0]      pick_idx;
  logic [IDXW-1:0]      last_q, last_d;
  logic                 gnt_cyc;
  logic                 gnt_stb;
  logic                 rsp_any;
  logic                 timeout_c;

  rr_priority_picker #(
    .N    (NUM_CORES),
    .IDXW (IDXW)
  ) u_picker (
    .req        (wbm.cyc),
    .last_grant (last_q),
    .grant      (pick)
  );

  // Binary index of the picked core, recorded as the next last_grant
  always_comb begin
    pick_idx = last_q;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (pick[i]) pick_idx = IDXW'(i);
    end
  end

  // Downstream request mux; grant_q is zero outside BUSY so idle drives 0
  always_comb begin
    wbs.adr   = '0;
    wbs.dat_w = '0;
    wbs.sel   = '0;
    wbs.we    = 1'b0;
    wbs.cti   = CTI_CLASSIC;
    wbs.bte   = BTE_LINEAR;
    gnt_cyc   = 1'b0;
    gnt_stb   = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (grant_q[i]) begin
        wbs.adr   = wbm.adr[i*AW +: AW];
        wbs.dat_w = wbm.dat_w[i*DW +: DW];
        wbs.sel   = wbm.sel[i*SW +: SW];
        wbs.we    = wbm.we[i];
        wbs.cti   = wbm.cti[i*CTI_W +: CTI_W];
        wbs.bte   = wbm.bte[i*BTE_W +: BTE_W];
        gnt_cyc   = wbm.cyc[i];
        gnt_stb   = wbm.stb[i];
      end
    end
    wbs.cyc = gnt_cyc & ~timeout_c;
    wbs.stb = gnt_stb & ~timeout_c;
  end

  // Responses reach only the granted core; read data is broadcast
  assign rsp_any   = wbs.ack | wbs.err | wbs.rty;
  assign wbm.ack   = grant_q & {NUM_CORES{wbs.ack}};
  assign wbm.err   = grant_q & {NUM_CORES{wbs.err | timeout_c}};
  assign wbm.rty   = grant_q & {NUM_CORES{wbs.rty}};
  assign wbm.dat_r = {NUM_CORES{wbs.dat_r}};
  assign grant_o   = grant_q;

`ifdef WB_ARB_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Count unanswered strobe cycles; any response or leaving BUSY clears
  always_comb begin
    wdog_d    = '0;
    timeout_c = 1'b0;
    if (state_q == ST_BUSY) begin
      if (wdog_q == WDOG_W'(TIMEOUT)) begin
        timeout_c = 1'b1;
      end else if (gnt_cyc && gnt_stb && !rsp_any) begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) wdog_q <= '0;
    else            wdog_q <= wdog_d;
  end
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  // TIMEOUT only matters when the watchdog is compiled in
  assign unused_timeout = ^{WDOG_W'(TIMEOUT), rsp_any};
`endif

  // Next-state / grant logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|wbm.cyc) begin
          state_d = ST_BUSY;
          grant_d = pick;
          last_d  = pick_idx;
        end
      end
      ST_BUSY: begin
        if (!gnt_cyc || timeout_c) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; last_grant resets to N-1 so core 0 wins first
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDXW'(NUM_CORES - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_core_arbiter.sv
// Randomized self-checking bench for wb_core_arbiter (4 cores).
// Reference model: owner index (-1 idle) plus last winner, advanced by
// the round-robin and hold-while-cyc rules; bench masters issue single
// and burst transfers, bench slave answers with bounded random stalls.
module tb_wb_core_arbiter;
  import wb_arb_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] grant;

  always #5 clk = ~clk;

  wb_core_arbiter_if #(.LANES(N), .AW(AW), .DW(DW)) wbm_bus ();
  wb_core_arbiter_if #(.LANES(1), .AW(AW), .DW(DW)) wbs_bus ();

  wb_core_arbiter #(
    .NUM_CORES (N),
    .AW        (AW),
    .DW        (DW),
    .TIMEOUT   (TMO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbm       (wbm_bus),
    .wbs       (wbs_bus),
    .grant_o   (grant)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // bench masters
  bit   [N-1:0]  m_act;
  bit            m_burst [N];
  bit            m_we    [N];
  int            m_beats [N];
  int            m_gap   [N];
  logic [AW-1:0] m_adr   [N];

  // bench slave
  logic          s_ack, s_err, s_rty;
  logic [DW-1:0] s_dat;
  int            stall;
  int            ack_pct;
  int            start_pct;

  // reference model
  int owner;
  int last;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2:0] cti_of(input int i);
    if (!m_act[i] || !m_burst[i]) return CTI_CLASSIC;
    return (m_beats[i] > 1) ? CTI_INC_BURST : CTI_END_BURST;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      wbm_bus.cyc[i]            = m_act[i];
      wbm_bus.stb[i]            = m_act[i];
      wbm_bus.we[i]             = m_we[i];
      wbm_bus.adr[i*AW +: AW]   = m_adr[i];
      wbm_bus.dat_w[i*DW +: DW] = ~m_adr[i];
      wbm_bus.sel[i*4 +: 4]     = 4'hf;
      wbm_bus.cti[i*3 +: 3]     = cti_of(i);
      wbm_bus.bte[i*2 +: 2]     = BTE_LINEAR;
    end
    wbs_bus.ack[0] = s_ack;
    wbs_bus.err[0] = s_err;
    wbs_bus.rty[0] = s_rty;
    wbs_bus.dat_r  = s_dat;
  endtask

  // One cycle: drive at negedge, check 1 time unit later, advance model
  task automatic step();
    logic [N-1:0]  oh;
    logic          exp_cyc;
    logic [AW-1:0] exp_adr;
    logic          exp_we;
    logic [2:0]    exp_cti;
    int            cur;
    int            r;
    bit            found;

    for (int i = 0; i < N; i++) begin
      if (!m_act[i]) begin
        if (m_gap[i] > 0) m_gap[i]--;
        else if ($urandom_range(99) < 32'(start_pct)) begin
          m_act[i]   = 1'b1;
          m_beats[i] = $urandom_range(1, 4);
          m_burst[i] = m_beats[i] > 1;
          m_adr[i]   = $urandom;
          m_we[i]    = 1'($urandom_range(1));
        end
      end
    end

    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    s_dat = $urandom;
    if (owner >= 0 && m_act[owner]) begin
      if (stall >= 3 || $urandom_range(99) < 32'(ack_pct)) begin
        r = $urandom_range(99);
        if (r < 5)       s_err = 1'b1;
        else if (r < 10) s_rty = 1'b1;
        else             s_ack = 1'b1;
        stall = 0;
      end else stall++;
    end else stall = 0;
    drive_bus();
    #1;

    oh = '0; exp_cyc = 1'b0; exp_adr = '0; exp_we = 1'b0; exp_cti = CTI_CLASSIC;
    if (owner >= 0) begin
      oh[owner] = 1'b1;
      exp_cyc   = m_act[owner];
      exp_adr   = m_adr[owner];
      exp_we    = m_we[owner];
      exp_cti   = cti_of(owner);
    end
    check("grant", grant, oh);
    check("wbs_cyc", wbs_bus.cyc, exp_cyc);
    check("wbs_stb", wbs_bus.stb, exp_cyc);
    check("wbs_adr", wbs_bus.adr, exp_adr);
    check("wbs_we", wbs_bus.we, exp_we);
    check("wbs_cti", wbs_bus.cti, exp_cti);
    check("wbm_ack", wbm_bus.ack, s_ack ? oh : '0);
    check("wbm_err", wbm_bus.err, s_err ? oh : '0);
    check("wbm_rty", wbm_bus.rty, s_rty ? oh : '0);
    check("wbm_dat", wbm_bus.dat_r, {N{s_dat}});

    cur = owner;
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && m_act[(last + k) % N]) begin
          owner = (last + k) % N;
          found = 1'b1;
        end
      end
      if (found) last = owner;
    end else if (!m_act[owner]) begin
      owner = -1;
    end

    if (cur >= 0 && (s_ack || s_err || s_rty)) begin
      m_beats[cur]--;
      if (m_beats[cur] == 0) begin
        m_act[cur] = 1'b0;
        m_gap[cur] = $urandom_range(1, 3);
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_masters();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 1'b0; m_burst[i] = 1'b0; m_we[i] = 1'b0;
      m_beats[i] = 0; m_gap[i] = 0; m_adr[i] = '0;
    end
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
    stall = 0;
  endtask

  initial begin
    int  lowest;
    bit  hit;

    clear_masters();
    owner = -1; last = N - 1;
    ack_pct = 70; start_pct = 0;
    drive_bus();

    #1 rst_n = 1'b0;
    #2;
    check("rst_grant", grant, '0);
    check("rst_wbs_cyc", wbs_bus.cyc, 1'b0);
    check("rst_wbs_stb", wbs_bus.stb, 1'b0);
    check("rst_wbm_ack", wbm_bus.ack, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // cores 0 and 2 request together
    m_act[0] = 1'b1; m_beats[0] = 1; m_adr[0] = 32'h1000_0000;
    m_act[2] = 1'b1; m_beats[2] = 1; m_adr[2] = 32'h2000_0000;
    ack_pct = 100;
    step();
    check("pair_first", grant, 4'b0001);
    step();
    step();
    check("pair_idle", grant, 4'b0000);
    step();
    check("pair_second", grant, 4'b0100);
    repeat (4) step();

    // saturated requests, then sparse traffic
    ack_pct = 60; start_pct = 100;
    repeat (400) step();
    start_pct = 30;
    repeat (1500) step();

    // reset in the middle of a burst
    hit = 1'b0;
    for (int t = 0; t < 2000 && !hit; t++) begin
      if (owner >= 0 && m_act[owner] && m_burst[owner] && m_beats[owner] >= 2) hit = 1'b1;
      else step();
    end
    check("rst_burst_found", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_grant", grant, '0);
    check("midrst_wbs_cyc", wbs_bus.cyc, 1'b0);
    check("midrst_ack", wbm_bus.ack, '0);
    owner = -1; last = N - 1; stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    start_pct = 0;
    lowest = -1;
    for (int i = N - 1; i >= 0; i--) if (m_act[i]) lowest = i;
    step();
    if (lowest >= 0) check("midrst_next", grant, N'(1 << lowest));
    start_pct = 30;
    repeat (200) step();

    // watchdog: slave never answers
    rst_n = 1'b0;
    clear_masters();
    drive_bus();
    @(negedge clk);
    rst_n = 1'b1;
    m_act[1] = 1'b1; m_beats[1] = 1; m_adr[1] = 32'hdead_0000;
    drive_bus();
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      #1;
`ifdef WB_ARB_WATCHDOG_EN
      if (k < int'(TMO)) begin
        check("wd_quiet", wbm_bus.err, '0);
        check("wd_stb", wbs_bus.stb, 1'b1);
        check("wd_busy", grant, 4'b0010);
      end else if (k == int'(TMO)) begin
        check("wd_err", wbm_bus.err, 4'b0010);
        check("wd_cyc_forced", wbs_bus.cyc, 1'b0);
        check("wd_stb_forced", wbs_bus.stb, 1'b0);
        m_act[1] = 1'b0;
        drive_bus();
      end else if (k == int'(TMO) + 1) begin
        check("wd_idle", grant, '0);
      end
`else
      check("wd_noerr", wbm_bus.err, '0);
      check("wd_held", grant, 4'b0010);
`endif
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
